// File: rtl/cmd_pkg.sv
// Shared command-bus definitions: opcodes, capture control fields and the
// capture engine state encoding.
package cmd_pkg;

  localparam logic [7:0] CMD_WAVE_UPLOAD   = 8'hFE;
  localparam logic [7:0] CMD_WAVE_DATA     = 8'hFF;
  localparam logic [7:0] CMD_CAPTURE       = 8'hFD;
  localparam int         CAP_PAYLOAD_BYTES = 5;

  typedef struct packed {
    logic        trig_en;
    logic [15:0] count;
    logic [15:0] decim;
  } capture_ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_CMD,
    ST_ARM,
    ST_CAPTURE,
    ST_TX
  } cap_state_t;

  // Zero means one sample; anything above the RAM depth is clamped to it.
  function automatic logic [15:0] clamp_count(input logic [15:0] n, input int unsigned max_n);
    if (n == 16'd0) return 16'd1;
    if (32'(n) > max_n) return 16'(max_n);
    return n;
  endfunction

  function automatic logic [15:0] fix_decim(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_ram #(
  parameter int DW    = 14,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/capture_upload_handler.sv
// Capture engine: decodes a capture command, stores decimated ADC samples in
// RAM, then streams a length header plus the samples to the upload arbiter.
module capture_upload_handler
  import cmd_pkg::cap_state_t, cmd_pkg::capture_ctrl_t, cmd_pkg::ST_IDLE, cmd_pkg::ST_RX_CMD,
         cmd_pkg::ST_ARM, cmd_pkg::ST_CAPTURE, cmd_pkg::ST_TX;
#(
  parameter int unsigned MAX_SAMPLES = 4096,
  parameter logic [7:0]  CMD_CAPTURE = cmd_pkg::CMD_CAPTURE,
  parameter logic [7:0]  SOURCE_ID   = 8'h0C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_data_index,
  input  logic        cmd_start,
  input  logic        cmd_data_valid,
  input  logic        cmd_done,
  output logic        cmd_ready,
  input  logic [13:0] adc_data,
  input  logic        adc_valid,
  input  logic        ext_trig,
  output logic        upload_req,
  output logic [7:0]  upload_source,
  output logic [7:0]  upload_data,
  output logic        upload_valid,
  input  logic        upload_ready,
  output logic        busy
);

  localparam int AW = $clog2(MAX_SAMPLES);
  localparam int NB = cmd_pkg::CAP_PAYLOAD_BYTES;

  cap_state_t    state_q, state_d;
  capture_ctrl_t ctrl_q, ctrl_d;
  logic [NB-1:0] rx_mask_q, rx_mask_d;
  logic [15:0]   n_q, n_d, d_q, d_d, dcnt_q, dcnt_d, cnt_q, cnt_d;
  logic [16:0]   idx_q, idx_d, total_bytes;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          trig_q;
  logic          req_q, req_d, valid_q, valid_d, busy_q, busy_d, rdy_q, rdy_d;
  logic [7:0]    data_q, data_d, tx_byte;
  logic          wr_en, rd_en, load;
  logic [13:0]   rd_data;
  logic          unused_cmd_length;

  assign unused_cmd_length = ^cmd_length;
  assign total_bytes       = {n_q, 1'b0} + 17'd2;

  capture_ram #(.DW(14), .DEPTH(MAX_SAMPLES)) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q[AW-1:0]),
    .wr_data_i (adc_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rptr_q),
    .rd_data_o (rd_data)
  );

  // Frame layout: N high, N low, then low/high byte of every stored sample.
  always_comb begin
    tx_byte = 8'h00;
    if (idx_q == 17'd0)      tx_byte = n_q[15:8];
    else if (idx_q == 17'd1) tx_byte = n_q[7:0];
    else if (!idx_q[0])      tx_byte = rd_data[7:0];
    else                     tx_byte = {2'b00, rd_data[13:8]};
  end

  always_comb begin
    state_d = state_q;  ctrl_d = ctrl_q;  rx_mask_d = rx_mask_q;
    n_d = n_q;  d_d = d_q;  dcnt_d = dcnt_q;  cnt_d = cnt_q;
    idx_d = idx_q;  rptr_d = rptr_q;
    req_d = req_q;  valid_d = valid_q;  data_d = data_q;
    wr_en = 1'b0;  rd_en = 1'b0;  load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start && cmd_type == CMD_CAPTURE) begin
          state_d   = ST_RX_CMD;
          rx_mask_d = '0;
        end
      end
      ST_RX_CMD: begin
        if (cmd_data_valid) begin
          case (cmd_data_index)
            16'd0: begin ctrl_d.trig_en     = cmd_data[0]; rx_mask_d[0] = 1'b1; end
            16'd1: begin ctrl_d.count[15:8] = cmd_data;    rx_mask_d[1] = 1'b1; end
            16'd2: begin ctrl_d.count[7:0]  = cmd_data;    rx_mask_d[2] = 1'b1; end
            16'd3: begin ctrl_d.decim[15:8] = cmd_data;    rx_mask_d[3] = 1'b1; end
            16'd4: begin ctrl_d.decim[7:0]  = cmd_data;    rx_mask_d[4] = 1'b1; end
            default: ;
          endcase
        end
        if (cmd_done) begin
          if (&rx_mask_d) begin
            state_d = ST_ARM;
            n_d     = cmd_pkg::clamp_count(ctrl_d.count, MAX_SAMPLES);
            d_d     = cmd_pkg::fix_decim(ctrl_d.decim);
            cnt_d   = '0;
            dcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ARM: begin
        if (!ctrl_q.trig_en || (ext_trig && !trig_q)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // dcnt_q==0 marks the strobe to keep; it reloads with D-1 after each store.
        if (adc_valid) begin
          if (dcnt_q == 16'd0) begin
            wr_en  = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            dcnt_d = d_q - 16'd1;
            if (cnt_d == n_q) begin
              state_d = ST_TX;
              req_d   = 1'b1;
              idx_d   = '0;
              rptr_d  = '0;
            end
          end else begin
            dcnt_d = dcnt_q - 16'd1;
          end
        end
      end
      ST_TX: begin
        load = (!valid_q || upload_ready) && (idx_q != total_bytes);
        if (load) begin
          data_d  = tx_byte;
          valid_d = 1'b1;
          idx_d   = idx_q + 17'd1;
          // Prefetch the next sample while its predecessor's high byte goes out.
          if (idx_q == 17'd0 || (idx_q[0] && idx_q >= 17'd3)) begin
            rd_en  = 1'b1;
            rptr_d = rptr_q + 1'b1;
          end
        end else if (valid_q && upload_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE) || (state_d == ST_RX_CMD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  ctrl_q <= '0;  rx_mask_q <= '0;
      n_q <= 16'd1;  d_q <= 16'd1;  dcnt_q <= '0;  cnt_q <= '0;
      idx_q <= '0;  rptr_q <= '0;  trig_q <= 1'b0;
      req_q <= 1'b0;  valid_q <= 1'b0;  data_q <= 8'h00;
      busy_q <= 1'b0;  rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;  ctrl_q <= ctrl_d;  rx_mask_q <= rx_mask_d;
      n_q <= n_d;  d_q <= d_d;  dcnt_q <= dcnt_d;  cnt_q <= cnt_d;
      idx_q <= idx_d;  rptr_q <= rptr_d;  trig_q <= ext_trig;
      req_q <= req_d;  valid_q <= valid_d;  data_q <= data_d;
      busy_q <= busy_d;  rdy_q <= rdy_d;
    end
  end

  assign cmd_ready     = rdy_q;
  assign busy          = busy_q;
  assign upload_req    = req_q;
  assign upload_valid  = valid_q;
  assign upload_data   = data_q;
  assign upload_source = SOURCE_ID;

endmodule

// File: tb/tb_capture_upload_handler.sv
// Directed + randomized bench: the expected frame is rebuilt from the driven
// ADC strobes using the capture rules (clamping, decimation, byte order).
module tb_capture_upload_handler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_type = '0;
  logic [15:0] cmd_length = '0;
  logic [7:0]  cmd_data = '0;
  logic [15:0] cmd_data_index = '0;
  logic        cmd_start = 1'b0, cmd_data_valid = 1'b0, cmd_done = 1'b0;
  logic        cmd_ready;
  logic [13:0] adc_data = '0;
  logic        adc_valid = 1'b0, ext_trig = 1'b0;
  logic        upload_req, upload_valid, busy;
  logic [7:0]  upload_source, upload_data;
  logic        upload_ready = 1'b1;

  always #5 clk = ~clk;

  capture_upload_handler dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
    .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
    .adc_data(adc_data), .adc_valid(adc_valid), .ext_trig(ext_trig),
    .upload_req(upload_req), .upload_source(upload_source), .upload_data(upload_data),
    .upload_valid(upload_valid), .upload_ready(upload_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Upload-side monitor, sampled on the falling edge.
  logic [7:0] got[$];
  int         stall_viol = 0;
  int         req_cycles = 0;
  logic       mon_clr = 1'b0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got.delete();
      stall_viol = 0;
      req_cycles = 0;
      pv = 1'b0;
    end else if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!upload_valid || upload_data !== pd)) stall_viol++;
      if (upload_valid && !upload_req) stall_viol++;
      if (upload_req) req_cycles++;
      if (upload_valid && upload_ready) got.push_back(upload_data);
      pv = upload_valid;
      pr = upload_ready;
      pd = upload_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] typ, input logic [7:0] pl [5], input int nb);
    cmd_type   = typ;
    cmd_length = 16'(nb);
    cmd_start  = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      cmd_data       = pl[i];
      cmd_data_index = 16'(i);
      cmd_data_valid = 1'b1;
      step();
    end
    cmd_data_valid = 1'b0;
    cmd_done       = 1'b1;
    step();
    cmd_done = 1'b0;
  endtask

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > 4096) return 4096;
    return n;
  endfunction

  function automatic int eff_d(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // adc_mode: 0 constant cval, 1 random, 2 ramp starting at cval.
  task automatic run_capture(input string name, input logic trig, input int n_raw, input int d_raw,
                             input logic rand_ready, input int adc_mode, input logic [13:0] cval,
                             input logic mid_cmd, input int abort_at);
    logic [7:0]  pl [5];
    logic [13:0] strobes[$];
    logic [7:0]  exp[$];
    logic [15:0] n16, d16;
    logic [13:0] v;
    int ne, de, need, sent, cyc, exp_len, mm;
    logic done, mid_done;
    ne = eff_n(n_raw);
    de = eff_d(d_raw);
    need = (ne - 1) * de + 1;
    exp_len = 2 + 2 * ne;
    n16 = 16'(n_raw);
    d16 = 16'(d_raw);
    pl[0] = {7'($urandom), trig};
    pl[1] = n16[15:8];
    pl[2] = n16[7:0];
    pl[3] = d16[15:8];
    pl[4] = d16[7:0];
    clear_mon();
    send_cmd(8'hFD, pl, 5);
    if (trig) begin
      for (int i = 0; i < 6; i++) begin
        adc_valid = 1'b1;
        adc_data  = 14'($urandom);
        step();
      end
      check({name, "_arm_busy"}, busy, 1);
      check({name, "_arm_req"}, upload_req, 0);
      check({name, "_arm_cmd_ready"}, cmd_ready, 0);
      ext_trig  = 1'b1;
      adc_valid = 1'b1;
      adc_data  = 14'($urandom);
      step();
    end else begin
      adc_valid = 1'b0;
      step();
      step();
    end
    sent = 0;
    cyc = 0;
    done = 1'b0;
    mid_done = 1'b0;
    while (!done && cyc < 40000) begin
      ext_trig = 1'b0;
      if (sent < need + 2) begin
        case (adc_mode)
          0: v = cval;
          1: v = 14'($urandom);
          default: v = 14'(int'(cval) + sent);
        endcase
        adc_valid = 1'b1;
        adc_data  = v;
        strobes.push_back(v);
        sent++;
      end else begin
        adc_valid = 1'b0;
      end
      upload_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_cmd && !mid_done && got.size() >= 4) begin
        check({name, "_tx_cmd_ready"}, cmd_ready, 0);
        cmd_type  = 8'hFD;
        cmd_start = 1'b1;
        mid_done  = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
      step();
      cyc++;
      if (abort_at > 0 && got.size() >= abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check({name, "_rst_req"}, upload_req, 0);
        check({name, "_rst_valid"}, upload_valid, 0);
        check({name, "_rst_data"}, upload_data, 0);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_cmd_ready"}, cmd_ready, 1);
        adc_valid = 1'b0;
        cmd_start = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        $display("frame %s aborted by reset after %0d bytes", name, got.size());
        return;
      end
      if (got.size() >= exp_len && !upload_req) done = 1'b1;
    end
    adc_valid = 1'b0;
    cmd_start = 1'b0;
    upload_ready = 1'b1;
    exp.push_back(8'((ne >> 8) & 255));
    exp.push_back(8'(ne & 255));
    for (int k = 0; k < ne; k++) begin
      v = strobes[k * de];
      exp.push_back(v[7:0]);
      exp.push_back({2'b00, v[13:8]});
    end
    mm = 0;
    for (int k = 0; k < exp.size(); k++)
      if (k >= got.size() || got[k] !== exp[k]) mm++;
    check({name, "_done"}, 32'(done), 1);
    check({name, "_len"}, got.size(), exp.size());
    check({name, "_bytes_bad"}, mm, 0);
    check({name, "_stall"}, stall_viol, 0);
    if (!rand_ready) check({name, "_req_cycles"}, req_cycles, exp.size() + 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_cmd_ready_end"}, cmd_ready, 1);
    $display("frame %s N=%0d D=%0d trig=%0d bytes=%0d hdr=%02h%02h",
             name, n_raw, d_raw, trig, got.size(),
             (got.size() > 0) ? got[0] : 8'h00, (got.size() > 1) ? got[1] : 8'h00);
  endtask

  task automatic idle_probe(input string name, input logic [7:0] typ, input int nb);
    logic [7:0] pl [5];
    pl = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
    clear_mon();
    send_cmd(typ, pl, nb);
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1'b1;
      adc_data  = 14'($urandom);
      step();
    end
    adc_valid = 1'b0;
    check({name, "_req_cycles"}, req_cycles, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_cmd_ready"}, cmd_ready, 1);
    $display("command %s type=%02h bytes=%0d ignored", name, typ, nb);
  endtask

  initial begin
    repeat (3) step();
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_req", upload_req, 0);
    check("reset_valid", upload_valid, 0);
    check("reset_data", upload_data, 0);
    check("reset_busy", busy, 0);
    check("source_id", upload_source, 8'h0C);
    rst_n = 1'b1;
    step();

    run_capture("ramp_n4", 1'b0, 4, 1, 1'b0, 2, 14'd100, 1'b0, 0);
    run_capture("trig_n2_d3", 1'b1, 2, 3, 1'b0, 2, 14'($urandom_range(0, 8000)), 1'b0, 0);
    run_capture("backpressure", 1'b0, 5, 2, 1'b1, 0, 14'h3FFF, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      run_capture($sformatf("random%0d", i), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 24), $urandom_range(0, 4), 1'b1, 1, 14'd0, 1'b0, 0);
    run_capture("n0_d0", 1'b0, 0, 0, 1'b0, 1, 14'd0, 1'b0, 0);
    run_capture("n3_d0", 1'b0, 3, 0, 1'b0, 2, 14'd500, 1'b0, 0);
    run_capture("n5000", 1'b0, 5000, 1, 1'b0, 1, 14'd0, 1'b0, 0);
    idle_probe("short_fd", 8'hFD, 3);
    idle_probe("foreign_fc", 8'hFC, 5);
    run_capture("cmd_during_tx", 1'b0, 6, 1, 1'b1, 1, 14'd0, 1'b1, 0);
    run_capture("abort_tx", 1'b0, 8, 1, 1'b0, 1, 14'd0, 1'b0, 5);
    run_capture("after_abort", 1'b1, 2, 1, 1'b0, 1, 14'd0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_upload_handler.md
Name: capture_upload_handler

Overview:
- Reverse direction of the custom-waveform path: captures 14-bit ADC samples into on-chip RAM on host command, then streams them back to the host as a byte stream on the upload interface.
- Sits beside the waveform playback handler on the shared command bus, which it decodes, and drives the upload arbiter toward USB.
- Sample wire format mirrors the waveform upload payload: each sample is sent low byte first, then the high byte, with the high byte zero-padded.

Parameters:
- MAX_SAMPLES, 4096, capture RAM depth; power of two.
- CMD_CAPTURE, 8'hFD, cmd_type value this block accepts.
- SOURCE_ID, 8'h0C, value driven on upload_source.

Ports:
- clk  in  1  system clock; single clock domain. The ADC strobe is already synchronised to it.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_type  in  8  command opcode, valid at cmd_start.
- cmd_length  in  16  payload length, valid at cmd_start.
- cmd_data  in  8  payload byte.
- cmd_data_index  in  16  byte index within the payload.
- cmd_start  in  1  one-cycle pulse marking the start of a command.
- cmd_data_valid  in  1  one-cycle pulse marking a valid payload byte.
- cmd_done  in  1  one-cycle pulse marking the end of a command.
- cmd_ready  out  1  high when the block can accept payload bytes.
- adc_data  in  14  ADC sample.
- adc_valid  in  1  ADC sample strobe.
- ext_trig  in  1  external trigger, already synchronised.
- upload_req  out  1  requests the upload channel; held high for the whole frame.
- upload_source  out  8  constant SOURCE_ID.
- upload_data  out  8  stream byte.
- upload_valid  out  1  upload_data is valid.
- upload_ready  in  1  sink accepts the byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_ready=1, upload_req=0, upload_valid=0, upload_data=0, busy=0, state=IDLE. Reset mid-operation aborts immediately with no partial frame tail; RAM contents are don't-care.
- Command payload is 5 bytes:
  - idx0: control. Bit0 = wait for a rising edge on ext_trig. Other bits are ignored.
  - idx1-2: sample count N, big-endian.
  - idx3-4: decimation D, big-endian.
  - Bytes are latched by cmd_data_index. Other cmd_type values are ignored entirely.
- State machine:
  - IDLE → RX_CMD on cmd_start with cmd_type==CMD_CAPTURE.
  - RX_CMD → ARM on cmd_done if all 5 bytes were received. RX_CMD → IDLE on cmd_done if fewer than 5 bytes were received; no capture occurs.
  - ARM: if trigger mode, wait for ext_trig 0→1 (edge detected against a registered copy), then → CAPTURE. Otherwise → CAPTURE the next cycle.
  - CAPTURE: store one sample every D-th adc_valid strobe, starting with the first strobe after entry, into RAM at the write pointer. → TX after N samples have been stored.
  - TX: emit 2+2N bytes in this order: N[15:8], N[7:0], then for each sample {adc[7:0]}, {2'b00, adc[13:8]}. → IDLE after the last handshake.
- Width and boundary rules:
  - N==0 is treated as 1.
  - N>MAX_SAMPLES is clamped to MAX_SAMPLES. The clamped value is the one sent in the header.
  - D==0 is treated as 1.
  - The decimation counter is 16 bits and reloads on each stored sample.
- cmd_ready is high only in IDLE and RX_CMD. Commands arriving during ARM/CAPTURE/TX are ignored, and cmd_start has no effect in those states.
- Upload handshake:
  - upload_req rises on entry to TX. The first upload_valid may follow 1 cycle later.
  - A byte transfers when upload_valid & upload_ready.
  - upload_data is held stable while valid and not ready.
  - There are no bubbles required, but throughput must reach 1 byte/cycle under constant ready. RAM reads (1-cycle latency) are prefetched.
  - upload_valid and upload_req both drop in the cycle after the final transfer.
- adc_valid and ext_trig are ignored outside ARM/CAPTURE. adc_valid in the same cycle as ARM→CAPTURE is not captured.

Decomposition:
- Shared package cmd_pkg holds:
  - CMD_CAPTURE and the waveform-upload opcode constants.
  - A capture_ctrl_t struct (trig_en, count[15:0], decim[15:0]).
  - A state enum.
- One natural sub-module: capture_ram, a simple dual-port RAM with a 14-bit × MAX_SAMPLES synchronous read.

Test Plan:
- Immediate capture, N=4, D=1, ADC ramp 100,101,… with upload_ready=1 → bytes 00 04 64 00 65 00 66 00 67 00; upload_req high for exactly 10 transfers plus setup.
- Trigger mode with N=2, D=3, adc_valid every cycle; samples are captured only after ext_trig rises, then every 3rd strobe (values k, k+3) → frame 00 02 followed by those two samples; busy stays 1 in ARM until the trigger.
- Backpressure: upload_ready toggles randomly, adc=14'h3FFF → upload_data is stable while stalled; each sample byte pair is FF 3F; no dropped or duplicated bytes.
- Boundaries: N=0 → header 00 01 and one sample; N=5000 → header 10 00 and 4096 samples; D=0 behaves as D=1.
- Malformed or foreign commands: FD with only 3 bytes then cmd_done → back to IDLE, no upload_req; cmd_type FC → ignored, cmd_ready stays 1; cmd_start=FD during TX → frame unaffected.
- Assert rst_n low mid-TX → all outputs at reset values asynchronously; a new capture command afterwards works normally.
